// File: rtl/xor_sched_pkg.sv
// Shared types and helpers for the bit-serial XOR scheduler.
// Holds the FSM state encoding, the default sizes and the round-robin pick.
package xor_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int WIDTH_DEF = 8;
  localparam int NREQ_DEF  = 4;
  // Widest request vector rr_pick can search.
  localparam int RR_MAX    = 32;

  // Returns the first set bit of req at or after (last+1) mod nreq.
  // With no request set it returns last.
  function automatic int rr_pick(input logic [RR_MAX-1:0] req,
                                 input int                nreq,
                                 input int                last);
    int idx;
    rr_pick = last;
    // Walk from farthest to nearest, so the nearest hit is the one kept.
    for (int i = RR_MAX; i >= 1; i--) begin
      if (i <= nreq) begin
        idx = last + i;
        if (idx >= nreq) idx = idx - nreq;
        if (req[idx]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/xor2.sv
// The single shared two-input XOR gate used as the scheduler datapath.
module xor2 (
  input  logic a_i,
  input  logic b_i,
  output logic s_o
);

  assign s_o = a_i ^ b_i;

endmodule

// File: rtl/xor_serial_sched.sv
// Round-robin scheduler that shares one xor2 among NREQ requesters.
// Granted operands are XORed bit-serially, LSB first, one bit per clock;
// the result is returned together with the requester index.
// Optional feature macro: XOR_SERIAL_PARITY_EN adds parity_o (= ^res_o).
module xor_serial_sched
  import xor_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NREQ-1:0]           req_i,
  input  logic [NREQ*WIDTH-1:0]     a_i,
  input  logic [NREQ*WIDTH-1:0]     b_i,
  output logic [NREQ-1:0]           gnt_o,
  output logic                      busy_o,
  output logic [WIDTH-1:0]          res_o,
  output logic                      res_valid_o,
`ifdef XOR_SERIAL_PARITY_EN
  output logic [$clog2(NREQ)-1:0]   res_id_o,
  output logic                      parity_o
`else
  output logic [$clog2(NREQ)-1:0]   res_id_o
`endif
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(WIDTH + 1);

  state_e           r_state;
  state_e           w_next;
  logic [IDW-1:0]   r_last;
  logic [IDW-1:0]   r_win;
  logic [IDW-1:0]   w_pick;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic [WIDTH-1:0] w_res_next;
  logic [NREQ-1:0]  r_gnt;
  logic [WIDTH-1:0] r_res;
  logic [IDW-1:0]   r_res_id;
  logic             r_res_valid;
  logic             w_x;
  logic             w_last_bit;

  // The one shared gate sees the current LSBs of the operand shifters.
  xor2 u_xor2 (
    .a_i (r_a_sh[0]),
    .b_i (r_b_sh[0]),
    .s_o (w_x)
  );

  assign w_pick     = IDW'(rr_pick(RR_MAX'(req_i), NREQ, int'(r_last)));
  assign w_last_bit = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));
  // New bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
  assign w_res_next = (r_res_sh >> 1) | (WIDTH'(w_x) << (WIDTH - 1));

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; req_i is only looked at in IDLE.
  always_comb begin
    // NOTE: default first so no path leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      IDLE:    if (|req_i)     w_next = LOAD;
      LOAD:                    w_next = SHIFT;
      SHIFT:   if (w_last_bit) w_next = DONE;
      DONE:                    w_next = IDLE;
      default:                 w_next = IDLE;
    endcase
  end

  // Arbitration, operand capture, serial shifting and result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last      <= IDW'(NREQ - 1);
      r_win       <= '0;
      r_cnt       <= '0;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_res_sh    <= '0;
      r_gnt       <= '0;
      r_res       <= '0;
      r_res_id    <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_gnt       <= '0;
      r_res_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          // Grant is registered so it shows as a one-cycle pulse during LOAD.
          if (|req_i) begin
            r_gnt <= NREQ'(1) << w_pick;
            r_win <= w_pick;
          end
        end
        LOAD: begin
          r_a_sh   <= a_i[r_win*WIDTH +: WIDTH];
          r_b_sh   <= b_i[r_win*WIDTH +: WIDTH];
          r_res_sh <= '0;
          r_last   <= r_win;
          r_cnt    <= '0;
        end
        SHIFT: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_res_sh <= w_res_next;
          if (w_last_bit) begin
            // Result is registered on entry to DONE so it is valid with the pulse.
            r_res       <= w_res_next;
            r_res_id    <= r_last;
            r_res_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef XOR_SERIAL_PARITY_EN
  logic r_par_acc;
  logic r_parity;

  // Parity folds in one result bit per SHIFT cycle and lands with res_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_par_acc <= 1'b0;
      r_parity  <= 1'b0;
    end else if (r_state == LOAD) begin
      r_par_acc <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_par_acc <= r_par_acc ^ w_x;
      if (w_last_bit) r_parity <= r_par_acc ^ w_x;
    end
  end

  assign parity_o = r_parity;
`endif

  assign gnt_o       = r_gnt;
  assign busy_o      = (r_state != IDLE);
  assign res_o       = r_res;
  assign res_valid_o = r_res_valid;
  assign res_id_o    = r_res_id;

endmodule

// File: tb/tb_xor_serial_sched.sv
// Directed bench for xor_serial_sched (WIDTH=8, NREQ=4).
// Table-driven single-request vectors plus hand sequences for reset,
// held round-robin requests and reset in the middle of an operation.
module tb_xor_serial_sched;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [NREQ-1:0]       req_i;
  logic [NREQ*WIDTH-1:0] a_i;
  logic [NREQ*WIDTH-1:0] b_i;
  logic [NREQ-1:0]       gnt_o;
  logic                  busy_o;
  logic [WIDTH-1:0]      res_o;
  logic                  res_valid_o;
  logic [IDW-1:0]        res_id_o;
`ifdef XOR_SERIAL_PARITY_EN
  logic                  parity_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  xor_serial_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .gnt_o       (gnt_o),
    .busy_o      (busy_o),
    .res_o       (res_o),
    .res_valid_o (res_valid_o),
`ifdef XOR_SERIAL_PARITY_EN
    .res_id_o    (res_id_o),
    .parity_o    (parity_o)
`else
    .res_id_o    (res_id_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a;
    logic [NREQ*WIDTH-1:0] b;
    int                    exp_id;
    logic [WIDTH-1:0]      exp_res;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for a grant; n returns the number of falling edges waited.
  task automatic wait_gnt(output int n);
    n = 0;
    while (gnt_o == '0 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!res_valid_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
  endtask

  // One request from IDLE; req_i is dropped right after the grant.
  task automatic serve(input string name, input logic [NREQ-1:0] req,
                       input logic [NREQ*WIDTH-1:0] a, input logic [NREQ*WIDTH-1:0] b,
                       input int exp_id, input logic [WIDTH-1:0] exp_res);
    int n;
    req_i = req;
    a_i   = a;
    b_i   = b;
    wait_gnt(n);
    check({name, "_gnt_lat"}, n, 1);
    check({name, "_gnt"}, 32'(gnt_o), 32'(1) << exp_id);
    req_i = '0;
    wait_res(n);
    check({name, "_res_lat"}, n, WIDTH + 1);
    check({name, "_res"}, 32'(res_o), 32'(exp_res));
    check({name, "_id"}, 32'(res_id_o), 32'(exp_id));
`ifdef XOR_SERIAL_PARITY_EN
    check({name, "_par"}, 32'(parity_o), 32'(^exp_res));
`endif
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int t_prev;
    int n_valid;
    logic [WIDTH-1:0] rr_res [NREQ];

    vecs[0] = '{4'b0010, 32'h0000_A500, 32'h0000_3C00, 1, 8'h99};
    vecs[1] = '{4'b0011, 32'h0000_00F0, 32'h0000_000F, 0, 8'hFF};
    vecs[2] = '{4'b0011, 32'h0000_3300, 32'h0000_6600, 1, 8'h55};
    vecs[3] = '{4'b1001, 32'h8100_0000, 32'h4400_0000, 3, 8'hC5};
    vecs[4] = '{4'b1100, 32'h00FF_0000, 32'h0000_0000, 2, 8'hFF};
    vecs[5] = '{4'b0001, 32'h0000_0000, 32'h0000_0000, 0, 8'h00};
    vecs[6] = '{4'b0001, 32'h0000_0080, 32'h0000_0001, 0, 8'h81};
    rr_res[0] = 8'h41;
    rr_res[1] = 8'h32;
    rr_res[2] = 8'h23;
    rr_res[3] = 8'h14;

    // Reset held with every requester asserted: outputs stay quiet.
    rst_ni = 1'b0;
    req_i  = 4'hF;
    a_i    = 32'hFFFF_FFFF;
    b_i    = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check($sformatf("rst%0d_gnt", i), 32'(gnt_o), 0);
      check($sformatf("rst%0d_busy", i), 32'(busy_o), 0);
      check($sformatf("rst%0d_valid", i), 32'(res_valid_o), 0);
      check($sformatf("rst%0d_res", i), 32'(res_o), 0);
    end
    req_i  = '0;
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Table of single requests; expected ids follow the RR pointer from reset.
    for (int i = 0; i < 7; i++)
      serve($sformatf("v%0d", i), vecs[i].req, vecs[i].a, vecs[i].b,
            vecs[i].exp_id, vecs[i].exp_res);

    // Fresh reset, then all requesters held: grants 0,1,2,3,0, WIDTH+3 apart.
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    a_i    = 32'h0403_0201;
    b_i    = 32'h1020_3040;
    req_i  = 4'hF;
    t_prev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(n);
      check($sformatf("rr%0d_gnt", g), 32'(gnt_o), 32'(1) << (g % NREQ));
      if (g > 0) check($sformatf("rr%0d_gap", g), cyc - t_prev, WIDTH + 3);
      t_prev = cyc;
      if (g == 4) break;
      wait_res(n);
      check($sformatf("rr%0d_res", g), 32'(res_o), 32'(rr_res[g]));
      check($sformatf("rr%0d_id", g), 32'(res_id_o), g);
      @(negedge clk_i);
    end

    // Reset pulsed 4 cycles into SHIFT of the last grant: result discarded.
    req_i = '0;
    repeat (4) @(negedge clk_i);
    check("mid_busy_before", 32'(busy_o), 1);
    rst_ni = 1'b0;
    #1;
    check("mid_busy_rst", 32'(busy_o), 0);
    repeat (2) @(negedge clk_i);
    rst_ni  = 1'b1;
    n_valid = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(negedge clk_i);
      if (res_valid_o) n_valid++;
    end
    check("mid_no_valid", n_valid, 0);
    serve("post_rst", 4'b1001, 32'h0000_005A, 32'h0000_00A5, 0, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
